md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
Multi-cycle multiply/divide unit holding the architectural HI/LO registers. It sits beside the ALU in the execute path and consumes the two register-file read operands. It produces HI/LO for the register-file write-back mux, used by mfhi/mflo. Its busy flag feeds the controller stall logic, so mult/div/mthi/mtlo/mfhi/mflo issued during an operation are held off.

Parameters:
MULT_CYCLES, 5, cycles busy stays high for mult/multu (must be >= 1)
DIV_CYCLES, 10, cycles busy stays high for div/divu (must be >= 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  one-cycle request; qualifies md_op
md_op  input  3  operation select: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
A  input  32  operand rs (RF read data 1)
B  input  32  operand rt (RF read data 2)
HI  output  32  HI register (remainder / product high word)
LO  output  32  LO register (quotient / product low word)
busy  output  1  high while a mult/div is in flight

Behaviour:
- Reset (sampled at a clk edge): HI=0, LO=0, busy=0, counter=0, pending result discarded. Reset mid-operation aborts the operation; HI/LO are still 0 afterwards.
- Accept rule: start is honoured only when busy=0. start with busy=1 is ignored, including MTHI/MTLO. Undefined md_op codes are ignored.
- MTHI/MTLO accepted at edge T: HI (or LO) <= A at edge T. busy is unaffected. Zero latency.
- MULT/MULTU/DIV/DIVU accepted at edge T:
  - Operands are latched at T.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
  - busy=1 for cycles T+1 .. T+N.
  - At edge T+N, HI/LO take the result and busy drops to 0.
  - HI/LO keep their old values until edge T+N.
  - A new start may be accepted in the cycle busy is 0, i.e. at edge T+N+1 at the earliest.
- The result is computed combinationally from the latched operands and registered. A and B may change freely after T.
- MULT: signed 32x32 -> 64-bit product; HI = [63:32], LO = [31:0]. MULTU: same, unsigned.
- DIV: signed divide.
  - LO = quotient, truncated toward zero. HI = remainder, sign follows the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- DIVU: unsigned divide; LO = quotient, HI = remainder.
- Divide by zero (B latched = 0): busy still runs DIV_CYCLES, then HI/LO are left unchanged.
- HI/LO are plain register outputs; there is no bypass of in-flight results. The controller stalls mfhi/mflo while busy=1.
- No other simultaneous-event cases arise; accept and completion are mutually exclusive because of the busy gate.

State machine:
- IDLE: busy=0. Accepted mult/div -> RUN.
- RUN: counter decrements each cycle. When counter reaches 1, commit the result and go to IDLE.
- reset from any state -> IDLE.

Decomposition:
- md_op encodings (3-bit MD_* codes) go in the shared const.v alongside the existing ALU/NPC/EXT op codes. Parameter defaults are also exposed there as MD_MULT_CYCLES and MD_DIV_CYCLES.
- One natural sub-module: md_core, combinational 64-bit result from latched operands and op, including signed-division sign correction and the divide-by-zero flag.
- The sequential counter/FSM and HI/LO registers stay in md_unit.

Test Plan:
- Reset, then MULT A=0xFFFFFFFD(-3), B=7 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB. HI/LO stay 0 while busy.
- MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- MTHI A=0x12345678, then DIVU A=5, B=0 -> busy 10 cycles; HI stays 0x12345678, LO stays 0.
- Start MULT, pulse MTLO A=0xAAAA0000 at cycle T+2 (ignored), reassert MULT at T+3 (ignored) -> single completion at T+5 with the first MULT's values. LO is never 0xAAAA0000.
- Start DIV, assert reset at T+4 -> busy=0 at T+5, HI=LO=0, and no late commit at T+10.

Source files
------------

// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_pkg
// Purpose  : Operation codes, default latencies and FSM states for md_unit.
// Revision : 1.0 - initial release
// ============================================================================
package md_unit_pkg;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // Codes 3'd0 and 3'd7 are unused and are ignored by md_unit.
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_multicycle(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_core.sv
`default_nettype none
// ============================================================================
// Module   : md_core
// Purpose  : Combinational 64-bit mult/div result ({HI,LO}) from latched operands.
// Revision : 1.0 - initial release
// ============================================================================
module md_core
    import md_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic [31:0] w_num;
    logic [31:0] w_den_raw;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    always_comb begin
        w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        w_prod_u = {32'd0, a} * {32'd0, b};

        // Signed divide runs on magnitudes; signs are restored afterwards so the
        // quotient truncates toward zero and the remainder follows the dividend.
        w_signed_div = (op == MD_DIV);
        w_num        = (w_signed_div && a[31]) ? (32'd0 - a) : a;
        w_den_raw    = (w_signed_div && b[31]) ? (32'd0 - b) : b;
        w_den        = (w_den_raw == 32'd0) ? 32'd1 : w_den_raw;
        w_q_mag      = w_num / w_den;
        w_r_mag      = w_num % w_den;
        w_quot       = (w_signed_div && (a[31] ^ b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
        w_rem        = (w_signed_div && a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

        case (op)
            MD_MULT:          result = w_prod_s;
            MD_MULTU:         result = w_prod_u;
            MD_DIV, MD_DIVU:  result = {w_rem, w_quot};
            default:          result = 64'd0;
        endcase

        div_by_zero = md_is_div(op) && (b == 32'd0);
    end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle multiply/divide unit owning the HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [2:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_latch;
    logic               w_write_hi;
    logic               w_write_lo;
    logic               w_commit;
    logic [63:0]        w_result;
    logic               w_div_by_zero;

    md_core u_md_core (
        .op          (r_op),
        .a           (r_a),
        .b           (r_b),
        .result      (w_result),
        .div_by_zero (w_div_by_zero)
    );

    // Starts are only examined in IDLE, so busy gates every op including mthi/mtlo.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_latch     = 1'b0;
        w_write_hi  = 1'b0;
        w_write_lo  = 1'b0;
        w_commit    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (md_is_multicycle(md_op)) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_RUN;
                        w_count_nxt = md_is_div(md_op) ? c_DIV_LOAD : c_MULT_LOAD;
                    end else if (md_op == MD_MTHI) begin
                        w_write_hi  = 1'b1;
                    end else if (md_op == MD_MTLO) begin
                        w_write_lo  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (r_count == c_CNT_ONE) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_commit    = !w_div_by_zero;
                end else begin
                    w_count_nxt = r_count - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op <= 3'd0;
            r_a  <= 32'd0;
            r_b  <= 32'd0;
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_latch) begin
                r_op <= md_op;
                r_a  <= A;
                r_b  <= B;
            end
            if (w_write_hi) begin
                r_hi <= A;
            end
            if (w_write_lo) begin
                r_lo <= A;
            end
            if (w_commit) begin
                r_hi <= w_result[63:32];
                r_lo <= w_result[31:0];
            end
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Directed self-checking bench for md_unit with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    // Bench-side view of what HI/LO should currently hold.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .HI    (HI),
        .LO    (LO),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Present a request for one edge; returns at the negedge following acceptance.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'hDEAD_BEEF;
        B     = 32'h0BAD_F00D;
    endtask

    task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int ncyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        issue(op, a, b);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            n_total++;
            if (HI !== m_hi || LO !== m_lo) begin
                $display("FAIL %s_hold: HI=%h LO=%h while busy, required HI=%h LO=%h",
                         name, HI, LO, m_hi, m_lo);
            end else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if (cnt !== ncyc) $display("FAIL %s_busy_len: got %0d cycles, required %0d", name, cnt, ncyc);
        else n_pass++;
        n_total++;
        if (HI !== exp_hi) $display("FAIL %s_hi: got %h, required %h", name, HI, exp_hi);
        else n_pass++;
        n_total++;
        if (LO !== exp_lo) $display("FAIL %s_lo: got %h, required %h", name, LO, exp_lo);
        else n_pass++;
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (HI !== 32'd0) $display("FAIL reset_hi: got %h, required 00000000", HI); else n_pass++;
        n_total++;
        if (LO !== 32'd0) $display("FAIL reset_lo: got %h, required 00000000", LO); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_mult();
        run_md("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_md("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_negdivisor", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_md("divu", MD_DIVU, 32'd7, 32'd2, 10, 32'h0000_0001, 32'h0000_0003);
        run_md("div_overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    endtask

    task automatic test_div_zero();
        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        n_total++;
        if (HI !== 32'h1234_5678) $display("FAIL mthi_hi: got %h, required 12345678", HI); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL mthi_busy: got %b, required 0", busy); else n_pass++;
        issue(MD_MTLO, 32'd0, 32'd0);
        n_total++;
        if (LO !== 32'd0) $display("FAIL mtlo_lo: got %h, required 00000000", LO); else n_pass++;
        m_hi = 32'h1234_5678;
        m_lo = 32'd0;
        run_md("divu_by_zero", MD_DIVU, 32'd5, 32'd0, 10, 32'h1234_5678, 32'h0000_0000);
    endtask

    task automatic test_undefined_op();
        issue(3'd7, 32'h5555_5555, 32'd3);
        n_total++;
        if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo)
            $display("FAIL undef_op: busy=%b HI=%h LO=%h, required busy=0 HI=%h LO=%h",
                     busy, HI, LO, m_hi, m_lo);
        else n_pass++;
    endtask

    task automatic test_ignore_while_busy();
        issue(MD_MULT, 32'd3, 32'd5);
        @(negedge clk);
        start = 1'b1;
        md_op = MD_MTLO;
        A     = 32'hAAAA_0000;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1 || LO !== m_lo)
            $display("FAIL ignore_mtlo: busy=%b LO=%h, required busy=1 LO=%h", busy, LO, m_lo);
        else n_pass++;
        md_op = MD_MULT;
        A     = 32'd7;
        B     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        n_total++;
        if (busy !== 1'b1 || LO !== m_lo)
            $display("FAIL ignore_restart: busy=%b LO=%h, required busy=1 LO=%h", busy, LO, m_lo);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL ignore_busy_t4: got %b, required 1", busy); else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd15)
            $display("FAIL ignore_commit: busy=%b HI=%h LO=%h, required busy=0 HI=00000000 LO=0000000f",
                     busy, HI, LO);
        else n_pass++;
        repeat (12) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd15)
            $display("FAIL ignore_no_second: busy=%b HI=%h LO=%h, required busy=0 HI=00000000 LO=0000000f",
                     busy, HI, LO);
        else n_pass++;
        m_hi = 32'd0;
        m_lo = 32'd15;
    endtask

    task automatic test_back_to_back();
        run_md("b2b_mult", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000);
        run_md("b2b_divu", MD_DIVU, 32'd100, 32'd7, 10, 32'h0000_0002, 32'h0000_000E);
    endtask

    task automatic test_reset_mid_op();
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_total++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            $display("FAIL reset_abort: busy=%b HI=%h LO=%h, required busy=0 HI=00000000 LO=00000000",
                     busy, HI, LO);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            $display("FAIL reset_no_late_commit: busy=%b HI=%h LO=%h, required busy=0 HI=00000000 LO=00000000",
                     busy, HI, LO);
        else n_pass++;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_undefined_op();
        test_ignore_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
